// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter: iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide)
module rv_muldiv_iter #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     count;
    logic [2:0]        op_q;
    logic [XLEN:0]     acc;
    logic [XLEN-1:0]   lo, mcand, a_raw;
    logic              neg_q, sa_q, div0_q, ovf_q;
    logic              accept, a_signed, b_signed, sa, sb, div0, ovf, special, lt;
    logic [XLEN-1:0]   abs_a, abs_b, quo, rem, res_nx;
    logic [XLEN:0]     mul_sum, shifted, dsub;
    logic [2*XLEN-1:0] prod;

    // Operand decode at accept: signedness, magnitudes and the RISC-V divide special cases
    always_comb begin
        accept   = state == IDLE && start && !kill;
        a_signed = !(op == 3'b011 || (op[2] && op[0]));
        b_signed = a_signed && op != 3'b010;
        sa       = a_signed && a[XLEN-1];
        sb       = b_signed && b[XLEN-1];
        abs_a    = sa ? -a : a;
        abs_b    = sb ? -b : b;
        div0     = op[2] && b == '0;
        ovf      = op[2] && !op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
        special  = div0 || ovf;
    end

    // One radix-2 step for either operation, plus the sign fix-up applied in FIN
    always_comb begin
        mul_sum = acc + (lo[0] ? {1'b0, mcand} : '0);
        shifted = {acc[XLEN-1:0], lo[XLEN-1]};
        lt      = shifted < {1'b0, mcand};
        dsub    = shifted - {1'b0, mcand};
        prod    = neg_q ? -{acc[XLEN-1:0], lo} : {acc[XLEN-1:0], lo};
        quo     = neg_q ? -lo : lo;
        rem     = sa_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        res_nx  = !op_q[2] ? (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                  div0_q   ? (op_q[1] ? a_raw : '1) :
                  ovf_q    ? (op_q[1] ? '0 : a_raw) :
                  op_q[1]  ? rem : quo;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: kill always wins; special divides may skip straight to FIN
    always_comb begin
        state_nx = kill            ? IDLE :
                   state == IDLE   ? (start ? ((EARLY_OUT && special) ? FIN : CALC) : IDLE) :
                   state == CALC   ? (count == CW'(1) ? FIN : CALC) :
                   IDLE;
    end

    // Outputs decoded from state
    always_comb begin
        busy = state != IDLE;
    end

    // Datapath: operand latch, iteration, registered result and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
            count  <= '0;
            op_q   <= '0;
            acc    <= '0;
            lo     <= '0;
            mcand  <= '0;
            a_raw  <= '0;
            neg_q  <= 1'b0;
            sa_q   <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done <= state == FIN && !kill;
            if (state == FIN && !kill) result <= res_nx;
            if (accept) begin
                op_q   <= op;
                a_raw  <= a;
                acc    <= '0;
                lo     <= abs_a;
                mcand  <= abs_b;
                neg_q  <= sa ^ sb;
                sa_q   <= sa;
                div0_q <= div0;
                ovf_q  <= ovf;
                count  <= CW'(XLEN);
            end else if (state == CALC) begin
                count <= count - 1'b1;
                if (!op_q[2]) begin
                    acc <= {1'b0, mul_sum[XLEN:1]};
                    lo  <= {mul_sum[0], lo[XLEN-1:1]};
                end else begin
                    acc <= lt ? shifted : dsub;
                    lo  <= {lo[XLEN-2:0], !lt};
                end
            end
        end
    end
endmodule

// File: tb/tb_rv_muldiv_iter.sv
// tb_rv_muldiv_iter: directed scoreboard bench for the iterative multiply/divide unit
module tb_rv_muldiv_iter;
    typedef struct {
        logic [31:0] res;
        int          cyc;
        int          lat;
        string       tag;
    } exp_t;

    logic        clk, rst_n, start, kill, busy, done;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    int          cyc = 0, tests = 0, fails = 0, done_cnt = 0, kd = 0, n = 0;
    exp_t        sb[$];
    exp_t        me;

    rv_muldiv_iter #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .kill(kill), .busy(busy), .done(done), .result(result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
            else begin
                me = sb.pop_front();
                chk(me.tag, result, me.res);
                chk({me.tag, "_lat"}, 32'(cyc - me.cyc), 32'(me.lat));
            end
        end
    end

    task automatic push_exp(input logic [31:0] r, input int lat, input string tag);
        exp_t e;
        e.res = r; e.cyc = cyc; e.lat = lat; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input int lat, input string tag);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        push_exp(r, lat, tag);
    endtask

    task automatic wait_done(input int lat, input string tag);
        int k = 0, bc = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge clk);
            if (busy) bc++;
            k++;
        end
        chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
        if (lat > 0) chk({tag, "_busy_cycles"}, 32'(bc), 32'(lat));
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        rst_n = 1'b1;

        issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");          wait_done(33, "mul");
        issue(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");  wait_done(33, "mulh");
        issue(3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulhu"); wait_done(33, "mulhu");
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");wait_done(33, "mulhsu");
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div");          wait_done(33, "div");
        issue(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem");          wait_done(33, "rem");
        issue(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu");                    wait_done(33, "divu");
        issue(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu");                     wait_done(33, "remu");

        issue(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_by0");             wait_done(1, "divu_by0");
        issue(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "div_by0");              wait_done(1, "div_by0");
        issue(3'b110, 32'd5, 32'd0, 32'd5, 1, "rem_by0");                     wait_done(1, "rem_by0");
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");wait_done(1, "div_ovf");
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf");       wait_done(1, "rem_ovf");

        issue(3'b101, 32'd100, 32'd7, 32'd14, 33, "pre_kill");                wait_done(33, "pre_kill");
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div_kill");
        repeat (10) @(negedge clk);
        sb.delete();
        kd = done_cnt;
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        chk("kill_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("kill_result", result, 32'd14);
        chk("kill_no_done", 32'(done_cnt), 32'(kd));

        issue(3'b000, 32'd3, 32'd5, 32'd15, 33, "mul_busy");
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, "mul_busy");
        kd = done_cnt;
        repeat (40) @(negedge clk);
        chk("ignored_start_done", 32'(done_cnt), 32'(kd));
        chk("ignored_start_result", result, 32'd15);

        issue(3'b101, 32'd20, 32'd3, 32'd6, 33, "b2b_a");
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1; op = 3'b111; a = 32'd20; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        push_exp(32'd2, 33, "b2b_b");
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(33, "b2b_b");

        issue(3'b000, 32'd7, 32'd9, 32'd63, 33, "mul_rst");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 sb.delete();
        kd = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_no_done", 32'(done_cnt), 32'(kd));
        issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_after_rst");
        wait_done(33, "mul_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
